// File: rtl/vga_pkg.sv
// vga_pkg
// Shared definitions for the VGA raster timing generator: default
// 640x480@60 timing constants, the coordinate width and the coordinate type
// used by every producer/consumer of DrawX/DrawY.
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam int COORD_W = 10;

  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
// One raster axis: a counter that runs 0..TOTAL-1 and wraps, advancing only
// when enable is high. Used once for the horizontal axis (always enabled)
// and once for the vertical axis (enabled by the horizontal terminal count).
//
// Ports:
//   vga_clk     pixel clock
//   reset       synchronous active-high reset, forces count to 0
//   enable      advance the counter this cycle
//   count       current count (registered)
//   count_next  value count will take at the next edge when not in reset
//   tc          terminal count, high while count == TOTAL-1
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int TOTAL = H_TOTAL
) (
  input  logic               vga_clk,
  input  logic               reset,
  input  logic               enable,
  output logic [COORD_W-1:0] count,
  output logic [COORD_W-1:0] count_next,
  output logic               tc
);

  localparam coord_t LAST = coord_t'(TOTAL - 1);

  assign tc = (count == LAST);

  // Next value is exposed so the top can decode registered outputs that line
  // up with the counter in the same cycle.
  always_comb begin
    count_next = count;
    if (enable) begin
      count_next = tc ? '0 : count + coord_t'(1);
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// 640x480@60 VGA raster timing from the 25 MHz pixel clock. Produces the
// DrawX/DrawY/blank interface consumed by the renderers, active-low hs/vs for
// the DAC connector, per-line and per-frame strobes and a frame counter.
//
// Ports:
//   vga_clk      pixel clock (only clock)
//   reset        synchronous active-high reset
//   DrawX        current column, 0..H_TOTAL-1
//   DrawY        current row, 0..V_TOTAL-1
//   blank        1 = visible pixel (display enable), 0 = blanking
//   hs, vs       horizontal / vertical sync, active low
//   line_start   1-cycle pulse when DrawX == 0
//   frame_start  1-cycle pulse when (0,0) is reached through a wrap
//   frame_count  completed-frame counter, wraps 255 -> 0
//
// Configuration macro: VGA_PIPE_COMP_EN
//   When defined, blank/hs/vs pass through one extra register stage (reset
//   to 0/1/1) to match the 1-cycle synchronous ROM latency of the renderers.
module vga_timing_gen #(
  parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int H_FP      = vga_pkg::H_FP,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BP      = vga_pkg::H_BP,
  parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int V_FP      = vga_pkg::V_FP,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BP      = vga_pkg::V_BP
) (
  input  logic                        vga_clk,
  input  logic                        reset,
  output logic [vga_pkg::COORD_W-1:0] DrawX,
  output logic [vga_pkg::COORD_W-1:0] DrawY,
  output logic                        blank,
  output logic                        hs,
  output logic                        vs,
  output logic                        line_start,
  output logic                        frame_start,
  output logic [7:0]                  frame_count
);

  import vga_pkg::*;

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
  end

  localparam coord_t H_VIS_END  = coord_t'(H_VISIBLE);
  localparam coord_t H_SYNC_BEG = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t H_SYNC_END = coord_t'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam coord_t V_VIS_END  = coord_t'(V_VISIBLE);
  localparam coord_t V_SYNC_BEG = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t V_SYNC_END = coord_t'(V_VISIBLE + V_FP + V_SYNC - 1);

  coord_t hc, vc, hc_next, vc_next;
  logic   h_tc, v_tc;
  logic   frame_wrap;
  logic   blank_r, hs_r, vs_r;

  vga_axis_counter #(.TOTAL(H_TOTAL)) u_h_counter (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .enable     (1'b1),
    .count      (hc),
    .count_next (hc_next),
    .tc         (h_tc)
  );

  vga_axis_counter #(.TOTAL(V_TOTAL)) u_v_counter (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .enable     (h_tc),
    .count      (vc),
    .count_next (vc_next),
    .tc         (v_tc)
  );

  assign DrawX = hc;
  assign DrawY = vc;

  // (799, V_TOTAL-1) -> (0,0) is the only way into the origin other than
  // reset, so a reset-entered origin never raises frame_start.
  assign frame_wrap = h_tc & v_tc;

  // Outputs are decoded from the counters' next values so that, once
  // registered, they describe the same pixel as DrawX/DrawY.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      blank_r     <= 1'b0;
      hs_r        <= 1'b1;
      vs_r        <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      blank_r     <= (hc_next < H_VIS_END) && (vc_next < V_VIS_END);
      hs_r        <= !((hc_next >= H_SYNC_BEG) && (hc_next <= H_SYNC_END));
      vs_r        <= !((vc_next >= V_SYNC_BEG) && (vc_next <= V_SYNC_END));
      line_start  <= h_tc;
      frame_start <= frame_wrap;
      if (frame_wrap) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

`ifdef VGA_PIPE_COMP_EN
  logic blank_q, hs_q, vs_q;

  // Delay the display-enable and syncs by one pixel so they meet the pixel
  // data coming out of the renderers' synchronous ROMs.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      blank_q <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
    end else begin
      blank_q <= blank_r;
      hs_q    <= hs_r;
      vs_q    <= vs_r;
    end
  end

  assign blank = blank_q;
  assign hs    = hs_q;
  assign vs    = vs_q;
`else
  assign blank = blank_r;
  assign hs    = hs_r;
  assign vs    = vs_r;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Directed self-checking bench for vga_timing_gen. Horizontal timing uses the
// real 640x480 values; the vertical axis is shrunk (6 visible lines, 13 total)
// so that several whole frames fit in a short run. All expectations are
// hand-derived from those timing values.
module tb_vga_timing_gen;

  localparam int HV  = 640;
  localparam int HFP = 16;
  localparam int HS  = 96;
  localparam int HB  = 48;
  localparam int HT  = HV + HFP + HS + HB;
  localparam int VV  = 6;
  localparam int VFP = 2;
  localparam int VS  = 2;
  localparam int VB  = 3;
  localparam int VT  = VV + VFP + VS + VB;
  localparam int WAIT_MAX = 2 * HT * VT;

`ifdef VGA_PIPE_COMP_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       vga_clk;
  logic       reset;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       blank;
  logic       hs;
  logic       vs;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_count;

  int tests = 0;
  int fails = 0;

  vga_timing_gen #(
    .H_VISIBLE (HV),
    .H_FP      (HFP),
    .H_SYNC    (HS),
    .H_BP      (HB),
    .V_VISIBLE (VV),
    .V_FP      (VFP),
    .V_SYNC    (VS),
    .V_BP      (VB)
  ) dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .hs          (hs),
    .vs          (vs),
    .line_start  (line_start),
    .frame_start (frame_start),
    .frame_count (frame_count)
  );

  initial vga_clk = 1'b0;
  always #20 vga_clk = ~vga_clk;

  // Advance one clock; outputs are then sampled half a period after the edge.
  task automatic step();
    @(negedge vga_clk);
  endtask

  task automatic wait_pos(input int x, input int y, output bit ok);
    int n;
    n  = 0;
    ok = 1'b1;
    while (!(int'(DrawX) == x && int'(DrawY) == y)) begin
      if (n >= WAIT_MAX) begin
        ok = 1'b0;
        return;
      end
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (5) step();
    tests++; if (DrawX !== 10'd0) begin fails++; $display("[TB] FAIL rst_drawx: got %0d expected 0", DrawX); end
    tests++; if (DrawY !== 10'd0) begin fails++; $display("[TB] FAIL rst_drawy: got %0d expected 0", DrawY); end
    tests++; if (hs !== 1'b1) begin fails++; $display("[TB] FAIL rst_hs: got %b expected 1", hs); end
    tests++; if (vs !== 1'b1) begin fails++; $display("[TB] FAIL rst_vs: got %b expected 1", vs); end
    tests++; if (blank !== 1'b0) begin fails++; $display("[TB] FAIL rst_blank: got %b expected 0", blank); end
    tests++; if (line_start !== 1'b0) begin fails++; $display("[TB] FAIL rst_line_start: got %b expected 0", line_start); end
    tests++; if (frame_start !== 1'b0) begin fails++; $display("[TB] FAIL rst_frame_start: got %b expected 0", frame_start); end
    tests++; if (frame_count !== 8'd0) begin fails++; $display("[TB] FAIL rst_frame_count: got %0d expected 0", frame_count); end
    reset = 1'b0;
    step();
    tests++; if (DrawX !== 10'd1) begin fails++; $display("[TB] FAIL rel_drawx: got %0d expected 1", DrawX); end
    tests++; if (DrawY !== 10'd0) begin fails++; $display("[TB] FAIL rel_drawy: got %0d expected 0", DrawY); end
    tests++; if (blank !== 1'(P == 0)) begin fails++; $display("[TB] FAIL rel_blank: got %b expected %b", blank, 1'(P == 0)); end
    tests++; if (frame_start !== 1'b0) begin fails++; $display("[TB] FAIL rel_frame_start: got %b expected 0", frame_start); end
  endtask

  task automatic test_line();
    bit ok;
    int pos_err, blank_cnt, blank_fall, hs_cnt, hs_first, hs_last;
    int ls_cnt, ls_prev, ls_period;
    logic prev_blank;
    pos_err = 0; blank_cnt = 0; blank_fall = -1; hs_cnt = 0; hs_first = -1; hs_last = -1;
    ls_cnt = 0; ls_prev = -1; ls_period = -1;
    prev_blank = 1'b0;
    wait_pos(HT - 1, 0, ok);
    tests++; if (!ok) begin fails++; $display("[TB] FAIL line_wait: got timeout expected (%0d,0)", HT - 1); end
    for (int i = 0; i <= HT; i++) begin
      step();
      if (int'(DrawX) != i % HT || int'(DrawY) != 1 + i / HT) pos_err++;
      if (line_start === 1'b1) begin
        if (ls_prev >= 0) ls_period = i - ls_prev;
        ls_prev = i;
        ls_cnt++;
      end
      if (i < HT) begin
        if (blank === 1'b1) blank_cnt++;
        if (blank === 1'b0 && prev_blank === 1'b1 && blank_fall < 0) blank_fall = i;
        prev_blank = blank;
        if (hs === 1'b0) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = i;
          hs_last = i;
        end
      end
    end
    tests++; if (pos_err != 0) begin fails++; $display("[TB] FAIL line_position: got %0d wrong cycles expected 0", pos_err); end
    tests++; if (blank_cnt != HV) begin fails++; $display("[TB] FAIL line_blank_count: got %0d expected %0d", blank_cnt, HV); end
    tests++; if (blank_fall != HV + P) begin fails++; $display("[TB] FAIL line_blank_fall: got %0d expected %0d", blank_fall, HV + P); end
    tests++; if (hs_cnt != HS) begin fails++; $display("[TB] FAIL line_hs_width: got %0d expected %0d", hs_cnt, HS); end
    tests++; if (hs_first != HV + HFP + P) begin fails++; $display("[TB] FAIL line_hs_first: got %0d expected %0d", hs_first, HV + HFP + P); end
    tests++; if (hs_last != HV + HFP + HS - 1 + P) begin fails++; $display("[TB] FAIL line_hs_last: got %0d expected %0d", hs_last, HV + HFP + HS - 1 + P); end
    tests++; if (ls_cnt != 2) begin fails++; $display("[TB] FAIL line_start_count: got %0d expected 2", ls_cnt); end
    tests++; if (ls_period != HT) begin fails++; $display("[TB] FAIL line_start_period: got %0d expected %0d", ls_period, HT); end
  endtask

  task automatic test_frames();
    int n, vs_cnt, vs_x, vs_y;
    n = 0;
    while (frame_start !== 1'b1 && n < WAIT_MAX) begin
      step();
      n++;
    end
    tests++; if (frame_start !== 1'b1) begin fails++; $display("[TB] FAIL frame1_wait: got timeout expected frame_start"); end
    tests++; if (DrawX !== 10'd0 || DrawY !== 10'd0) begin fails++; $display("[TB] FAIL frame1_pos: got (%0d,%0d) expected (0,0)", DrawX, DrawY); end
    tests++; if (frame_count !== 8'd1) begin fails++; $display("[TB] FAIL frame1_count: got %0d expected 1", frame_count); end
    n = 0; vs_cnt = 0; vs_x = -1; vs_y = -1;
    do begin
      step();
      n++;
      if (vs === 1'b0) begin
        if (vs_cnt == 0) begin vs_x = int'(DrawX); vs_y = int'(DrawY); end
        vs_cnt++;
      end
    end while (frame_start !== 1'b1 && n < WAIT_MAX);
    tests++; if (n != HT * VT) begin fails++; $display("[TB] FAIL frame_period: got %0d expected %0d", n, HT * VT); end
    tests++; if (vs_cnt != HT * VS) begin fails++; $display("[TB] FAIL frame_vs_width: got %0d expected %0d", vs_cnt, HT * VS); end
    tests++; if (vs_x != P || vs_y != VV + VFP) begin fails++; $display("[TB] FAIL frame_vs_start: got (%0d,%0d) expected (%0d,%0d)", vs_x, vs_y, P, VV + VFP); end
    tests++; if (frame_count !== 8'd2) begin fails++; $display("[TB] FAIL frame2_count: got %0d expected 2", frame_count); end
  endtask

  task automatic test_boundary();
    bit ok;
    wait_pos(HV - 1, VV - 1, ok);
    tests++; if (!ok) begin fails++; $display("[TB] FAIL bnd_wait_vis: got timeout expected (%0d,%0d)", HV - 1, VV - 1); end
    tests++; if (blank !== 1'b1) begin fails++; $display("[TB] FAIL bnd_blank_639: got %b expected 1", blank); end
    step();
    tests++; if (blank !== 1'(P == 1)) begin fails++; $display("[TB] FAIL bnd_blank_640: got %b expected %b", blank, 1'(P == 1)); end
    step();
    tests++; if (blank !== 1'b0) begin fails++; $display("[TB] FAIL bnd_blank_641: got %b expected 0", blank); end
    wait_pos(HT - 1, VT - 1, ok);
    tests++; if (!ok) begin fails++; $display("[TB] FAIL bnd_wait_end: got timeout expected (%0d,%0d)", HT - 1, VT - 1); end
    tests++; if (frame_start !== 1'b0 || vs !== 1'b1) begin fails++; $display("[TB] FAIL bnd_last_pixel: got fs=%b vs=%b expected fs=0 vs=1", frame_start, vs); end
    step();
    tests++; if (DrawX !== 10'd0 || DrawY !== 10'd0) begin fails++; $display("[TB] FAIL bnd_wrap_pos: got (%0d,%0d) expected (0,0)", DrawX, DrawY); end
    tests++; if (frame_start !== 1'b1 || line_start !== 1'b1) begin fails++; $display("[TB] FAIL bnd_wrap_strobes: got fs=%b ls=%b expected fs=1 ls=1", frame_start, line_start); end
    tests++; if (frame_count !== 8'd3) begin fails++; $display("[TB] FAIL bnd_wrap_count: got %0d expected 3", frame_count); end
    tests++; if (blank !== 1'(P == 0)) begin fails++; $display("[TB] FAIL bnd_wrap_blank: got %b expected %b", blank, 1'(P == 0)); end
  endtask

  task automatic test_mid_reset();
    bit ok;
    wait_pos(300, 5, ok);
    tests++; if (!ok) begin fails++; $display("[TB] FAIL mid_wait: got timeout expected (300,5)"); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests++; if (DrawX !== 10'd0 || DrawY !== 10'd0) begin fails++; $display("[TB] FAIL mid_rst_pos: got (%0d,%0d) expected (0,0)", DrawX, DrawY); end
    tests++; if (hs !== 1'b1 || vs !== 1'b1 || blank !== 1'b0) begin fails++; $display("[TB] FAIL mid_rst_sync: got hs=%b vs=%b blank=%b expected 1 1 0", hs, vs, blank); end
    tests++; if (line_start !== 1'b0 || frame_start !== 1'b0) begin fails++; $display("[TB] FAIL mid_rst_strobes: got ls=%b fs=%b expected 0 0", line_start, frame_start); end
    tests++; if (frame_count !== 8'd0) begin fails++; $display("[TB] FAIL mid_rst_count: got %0d expected 0", frame_count); end
    step();
    tests++; if (DrawX !== 10'd1 || DrawY !== 10'd0) begin fails++; $display("[TB] FAIL mid_resume_pos: got (%0d,%0d) expected (1,0)", DrawX, DrawY); end
    tests++; if (frame_start !== 1'b0 || frame_count !== 8'd0) begin fails++; $display("[TB] FAIL mid_resume_frame: got fs=%b fc=%0d expected 0 0", frame_start, frame_count); end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_line();
    test_frames();
    test_boundary();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
